conv_sequencer: RTL
===================

// Module: conv_sequencer
// PURPOSE
//  Sequencer for the 9-instance 3x3 binary convolution array (one conv_module per tap).
//  Fetches the 9-bit weight word and image rows from a shared single-read-port memory.
//  Loads the taps, then streams every 3x3 window into the array with go and tap index enable.
//  Pops the array's negative flags into a sign bit, packs each output row and writes it out.
//  Sits between the top-level start/done handshake, the input memory and the tap array.
// PARAMETERS
//  IMG_W   16  image width = height in bits; one memory word = one image row, LSB = column 0
//  ADDR_W  12  memory read/write address width
// PORTS
//  clock             in   1         rising-edge clock
//  reset             in   1         asynchronous, active-high reset
//  start             in   1         request run; sampled only in IDLE
//  busy              out  1         high from the cycle after start is accepted through DONE
//  done              out  1         one-cycle pulse when the last output row has been written
//  mem_rd_en         out  1         read strobe; data is returned one cycle later
//  mem_rd_addr       out  ADDR_W    0 = weight word; 1..IMG_W = image rows 0..IMG_W-1
//  mem_rd_data       in   IMG_W     read data; weights in [8:0], tap k = 3*i+j
//  conv_load_weight  out  1         load conv_weight into all 9 taps
//  conv_weight       out  9         per-tap weight bit, 1 = +1, 0 = -1
//  conv_go           out  1         taps capture conv_data this cycle
//  conv_data         out  9         window bits, tap k = row r+i, column c+j
//  conv_idx_en       out  1         equals conv_go; enables tap index pipeline
//  conv_idx          out  4         column index c[3:0] tagged onto the window
//  neg_flags         in   9         tap negative flags, valid the cycle after conv_go
//  out_wr_en         out  1         output row write strobe
//  out_wr_addr       out  ADDR_W    output row r, 0..OW-1, where OW = IMG_W-2
//  out_wr_data       out  IMG_W-2   output row; bit c = result for window column c
// BEHAVIOUR
//  Reset: all outputs 0 and state = IDLE, asynchronously. Row, column and result registers clear.
//   Mid-run reset aborts immediately: no further reads or writes, no done pulse.
//   The taps keep their last weights because conv_load_weight is 0.
//  FSM: IDLE -> WREQ -> WLOAD -> RREQ -> RLAST -> COMP -> DRAIN -> WRITE -> (RREQ | DONE) -> IDLE.
//  IDLE: start=1 accepts the run; r=0. A start pulse in any other state is ignored.
//  WREQ (1 cycle): mem_rd_en=1, addr 0.
//  WLOAD (1 cycle): conv_load_weight=1, conv_weight=mem_rd_data[8:0].
//  RREQ (3 cycles, i=0..2): mem_rd_en=1, addr r+1+i. The data returned by each read is
//   latched into row buffer i-1 in the following cycle.
//  RLAST (1 cycle): latch row buffer 2; no read.
//  COMP (OW cycles, c=0..OW-1): conv_go=conv_idx_en=1, conv_idx=c[3:0], window taps from row buffers.
//  Result pipeline: in the cycle after each conv_go, n = popcount(neg_flags) and
//   result bit c-1 = (n <= 4), i.e. tap sum 9-2n > 0. The sum is odd, so it is never 0.
//  DRAIN (1 cycle): capture result bit OW-1; conv_go=0.
//  WRITE (1 cycle): out_wr_en=1, out_wr_addr=r, out_wr_data=result row.
//   If r==OW-1, go to DONE; else r++ and go to RREQ.
//  DONE (1 cycle): done=1, busy=1; then IDLE. A start in DONE is ignored.
//  Cycles per output row = OW+6. done is high in cycle 2+OW*(OW+6)+1 after the start edge
//   (283 for IMG_W=16).
//  All strobes are registered outputs, and only one of mem_rd_en and out_wr_en is high per cycle.
//   Addresses and data are 0 whenever their strobe is low.
// TESTING
//  T1 weights 9'h1FF, image all ones -> 14 writes, addr 0..13, data 14'h3FFF each.
//     done is high in cycle 283; busy falls after done.
//  T2 weights 9'h000, image all ones -> n=9 per window -> every out_wr_data = 14'h0000.
//  T3 weights 9'h1FF, image rows 1 and 2 = 0, all other rows ones ->
//     addr0 = 0, addr1 = 0, addr2..13 = 14'h3FFF.
//  T4 read trace for T1 -> mem_rd_addr sequence 0,1,2,3,2,3,4,3,4,5,...,14,15,16 with no gaps
//     inside each RREQ. conv_go runs of exactly 14 cycles.
//  T5 start pulses while busy, including in DONE -> ignored, with one done per accepted start.
//     Back-to-back start right after done -> second run identical to T1.
//  T6 reset raised in COMP of row 5 -> all outputs 0 in the same cycle and no write for row 5.
//     Reset released, then start -> full T1 result, addr 0..13.

Source files
------------

// File: rtl/conv_sequencer_if.sv
// Bundles the start/done handshake, the shared memory read port, the tap-array
// controls and the output row write port used by conv_sequencer.
interface conv_sequencer_if #(
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 12
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [IMG_W-1:0]  mem_rd_data;
    logic              conv_load_weight;
    logic [8:0]        conv_weight;
    logic              conv_go;
    logic [8:0]        conv_data;
    logic              conv_idx_en;
    logic [3:0]        conv_idx;
    logic [8:0]        neg_flags;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [IMG_W-3:0]  out_wr_data;

    modport master (
        input  start, mem_rd_data, neg_flags,
        output busy, done, mem_rd_en, mem_rd_addr, conv_load_weight, conv_weight,
               conv_go, conv_data, conv_idx_en, conv_idx, out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        output start, mem_rd_data, neg_flags,
        input  busy, done, mem_rd_en, mem_rd_addr, conv_load_weight, conv_weight,
               conv_go, conv_data, conv_idx_en, conv_idx, out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/conv_sequencer.sv
// Sequencer for the 3x3 binary convolution tap array: loads weights, buffers three
// image rows, streams every window into the taps and writes one packed output row per pass.
module conv_sequencer #(
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    conv_sequencer_if.master    bus
);
    localparam int OW    = IMG_W - 2;
    localparam int ROW_W = $clog2(IMG_W);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WREQ  = 4'd1,
        S_WLOAD = 4'd2,
        S_RREQ  = 4'd3,
        S_RLAST = 4'd4,
        S_COMP  = 4'd5,
        S_DRAIN = 4'd6,
        S_WRITE = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t            state_r, state_s;
    logic [ROW_W-1:0]  row_r, row_s;
    logic [1:0]        sub_r, sub_s;
    logic [COL_W-1:0]  col_r, col_s;

    logic              busy_r, done_r, rd_en_r, load_r, go_r, wr_en_r;
    logic [ADDR_W-1:0] rd_addr_r;

    logic [IMG_W-1:0]  row_buf_r [3];
    logic              go_d_r;
    logic [COL_W-1:0]  col_d_r;
    logic [OW-1:0]     result_r;
    logic [8:0]        window_s;

    // A window sums to 9-2n; it is positive exactly when at most four taps are negative.
    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 9; k++) begin
            n = n + {3'd0, v[k]};
        end
        return n;
    endfunction

    // Next-state and counter logic
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        sub_s   = 2'd0;
        col_s   = {COL_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                row_s = {ROW_W{1'b0}};
                if (bus.start) begin
                    state_s = S_WREQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WREQ:  state_s = S_WLOAD;
            S_WLOAD: state_s = S_RREQ;
            S_RREQ: begin
                if (sub_r == 2'd2) begin
                    state_s = S_RLAST;
                end else begin
                    sub_s = sub_r + 2'd1;
                end
            end
            S_RLAST: state_s = S_COMP;
            S_COMP: begin
                if (col_r == COL_W'(OW - 1)) begin
                    state_s = S_DRAIN;
                end else begin
                    col_s = col_r + COL_W'(1);
                end
            end
            S_DRAIN: state_s = S_WRITE;
            S_WRITE: begin
                if (row_r == ROW_W'(OW - 1)) begin
                    state_s = S_DONE;
                end else begin
                    row_s   = row_r + ROW_W'(1);
                    state_s = S_RREQ;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, counters and strobes; strobes are decoded from the next state so they leave flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            row_r     <= {ROW_W{1'b0}};
            sub_r     <= 2'd0;
            col_r     <= {COL_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            load_r    <= 1'b0;
            go_r      <= 1'b0;
            wr_en_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            row_r     <= row_s;
            sub_r     <= sub_s;
            col_r     <= col_s;
            busy_r    <= (state_s != S_IDLE);
            done_r    <= (state_s == S_DONE);
            rd_en_r   <= (state_s == S_WREQ) || (state_s == S_RREQ);
            rd_addr_r <= (state_s == S_RREQ) ? (ADDR_W'(row_s) + ADDR_W'(sub_s) + ADDR_W'(1))
                                             : {ADDR_W{1'b0}};
            load_r    <= (state_s == S_WLOAD);
            go_r      <= (state_s == S_COMP);
            wr_en_r   <= (state_s == S_WRITE);
        end
    end

    // Row buffers fill one cycle behind each read; results land one cycle behind each go
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                row_buf_r[i] <= {IMG_W{1'b0}};
            end
            go_d_r   <= 1'b0;
            col_d_r  <= {COL_W{1'b0}};
            result_r <= {OW{1'b0}};
        end else begin
            if (state_r == S_RREQ) begin
                case (sub_r)
                    2'd1:    row_buf_r[0] <= bus.mem_rd_data;
                    2'd2:    row_buf_r[1] <= bus.mem_rd_data;
                    default: row_buf_r[0] <= row_buf_r[0];
                endcase
            end else if (state_r == S_RLAST) begin
                row_buf_r[2] <= bus.mem_rd_data;
            end else begin
                row_buf_r[2] <= row_buf_r[2];
            end
            go_d_r  <= go_r;
            col_d_r <= col_r;
            if (go_d_r) begin
                result_r[col_d_r] <= (popcount9(bus.neg_flags) <= 4'd4);
            end else begin
                result_r <= result_r;
            end
        end
    end

    // Window gather: tap 3*i+j sees buffered row i at column c+j
    always_comb begin
        window_s = 9'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                window_s[3*i+j] = row_buf_r[i][col_r + COL_W'(j)];
            end
        end
    end

    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.mem_rd_en        = rd_en_r;
    assign bus.mem_rd_addr      = rd_addr_r;
    assign bus.conv_load_weight = load_r;
    assign bus.conv_weight      = load_r ? bus.mem_rd_data[8:0] : 9'd0;
    assign bus.conv_go          = go_r;
    assign bus.conv_idx_en      = go_r;
    assign bus.conv_idx         = go_r ? 4'(col_r) : 4'd0;
    assign bus.conv_data        = go_r ? window_s : 9'd0;
    assign bus.out_wr_en        = wr_en_r;
    assign bus.out_wr_addr      = wr_en_r ? ADDR_W'(row_r) : {ADDR_W{1'b0}};
    assign bus.out_wr_data      = wr_en_r ? result_r : {OW{1'b0}};
endmodule
